// File: rtl/jr_decoder.sv
// jr_decoder: decodes ring/Johnson code words to a sequence index and monitors sequence lock.
// Define JR_DECODER_ERRCNT_EN to implement the saturating err_count; otherwise it reads 0.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_HUNT | waiting for a first legal word
// S_ACQ  | counting consecutive in-sequence words toward LOCK_COUNT
// S_LOCK | locked; mismatches flywheel the reference and count misses
module jr_decoder #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 2,
  parameter int MISS_LIMIT = 2,
  localparam int IW        = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             j_r,
  input  logic [WIDTH-1:0] code_in,
  input  logic             code_valid,
  output logic [IW-1:0]    index,
  output logic             index_valid,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_count
);

  localparam logic [1:0] S_HUNT = 2'd0;
  localparam logic [1:0] S_ACQ  = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;

  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [RW-1:0]    run_q, run_d;
  logic [MW-1:0]    miss_q, miss_d;
  logic             mode_q, mode_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             iv_q, iv_d;
  logic             err_q, err_d;
  logic             locked_q;

  logic             legal;
  logic [IW-1:0]    dec_idx;
  logic [WIDTH-1:0] next_ref;
  logic             in_seq;

  // Pattern match against every legal word of the current mode.
  always_comb begin
    legal   = 1'b0;
    dec_idx = '0;
    if (mode_q) begin
      if (code_in == '0) begin
        legal   = 1'b1;
        dec_idx = IW'(1);
      end
      for (int n = 1; n <= WIDTH; n++) begin
        if (code_in == ~(ONES >> n)) begin
          legal   = 1'b1;
          dec_idx = IW'(1 + n);
        end
      end
      for (int m = 1; m < WIDTH; m++) begin
        if (code_in == (ONES >> (WIDTH - m))) begin
          legal   = 1'b1;
          dec_idx = IW'((2*WIDTH + 1 - m) % (2*WIDTH));
        end
      end
    end else begin
      for (int p = 0; p < WIDTH; p++) begin
        if (code_in == (ONE << p)) begin
          legal   = 1'b1;
          dec_idx = IW'((WIDTH - p) % WIDTH);
        end
      end
    end
  end

  assign next_ref = {(mode_q ? ~ref_q[0] : ref_q[0]), ref_q[WIDTH-1:1]};
  assign in_seq   = (code_in == next_ref);

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    run_d   = run_q;
    miss_d  = miss_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    iv_d    = 1'b0;
    err_d   = 1'b0;
    if (code_valid) begin
      if (j_r != mode_q) begin
        // Mode switch: the word was encoded under the other mode, so drop it.
        mode_d  = j_r;
        state_d = S_HUNT;
        run_d   = '0;
        miss_d  = '0;
      end else begin
        if (legal) begin
          iv_d  = 1'b1;
          idx_d = dec_idx;
        end
        case (state_q)
          S_HUNT: begin
            if (legal) begin
              ref_d = code_in;
              run_d = RW'(1);
              if (LOCK_COUNT == 1) begin
                state_d = S_LOCK;
                miss_d  = '0;
              end else begin
                state_d = S_ACQ;
              end
            end else begin
              err_d = 1'b1;
            end
          end
          S_ACQ: begin
            if (!legal) begin
              err_d   = 1'b1;
              state_d = S_HUNT;
            end else if (in_seq) begin
              ref_d = code_in;
              run_d = run_q + RW'(1);
              if (run_q + RW'(1) == RW'(LOCK_COUNT)) begin
                state_d = S_LOCK;
                miss_d  = '0;
              end
            end else begin
              ref_d = code_in;
              run_d = RW'(1);
            end
          end
          S_LOCK: begin
            if (in_seq) begin
              ref_d  = code_in;
              miss_d = '0;
            end else begin
              err_d  = 1'b1;
              ref_d  = next_ref;
              miss_d = miss_q + MW'(1);
              if (miss_q + MW'(1) == MW'(MISS_LIMIT)) begin
                state_d = S_HUNT;
              end
            end
          end
          default: state_d = S_HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_HUNT;
      ref_q    <= '0;
      run_q    <= '0;
      miss_q   <= '0;
      mode_q   <= j_r;
      idx_q    <= '0;
      iv_q     <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      run_q    <= run_d;
      miss_q   <= miss_d;
      mode_q   <= mode_d;
      idx_q    <= idx_d;
      iv_q     <= iv_d;
      err_q    <= err_d;
      locked_q <= (state_d == S_LOCK);
    end
  end

  assign index       = idx_q;
  assign index_valid = iv_q;
  assign locked      = locked_q;
  assign err         = err_q;

`ifdef JR_DECODER_ERRCNT_EN
  logic [7:0] ecnt_q, ecnt_d;

  always_comb begin
    ecnt_d = ecnt_q;
    if (err_d && (ecnt_q != 8'hFF)) begin
      ecnt_d = ecnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ecnt_q <= '0;
    end else begin
      ecnt_q <= ecnt_d;
    end
  end

  assign err_count = ecnt_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_jr_decoder.sv
// Self-checking bench for jr_decoder: sequence-position reference model plus directed literal checks.
// err_count expectations follow JR_DECODER_ERRCNT_EN.
module tb_jr_decoder;

  localparam int W  = 4;
  localparam int LC = 2;
  localparam int ML = 2;
  localparam int IW = $clog2(2*W);

  localparam int M_HUNT = 0;
  localparam int M_ACQ  = 1;
  localparam int M_LOCK = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          j_r;
  logic [W-1:0]  code_in;
  logic          code_valid;
  logic [IW-1:0] index;
  logic          index_valid;
  logic          locked;
  logic          err;
  logic [7:0]    err_count;

  int checks = 0;
  int errors = 0;

  jr_decoder #(.WIDTH(W), .LOCK_COUNT(LC), .MISS_LIMIT(ML)) dut (
    .clk(clk), .rstn(rstn), .j_r(j_r), .code_in(code_in), .code_valid(code_valid),
    .index(index), .index_valid(index_valid), .locked(locked), .err(err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Counter successor as defined for the code families.
  function automatic logic [W-1:0] nxt(input logic [W-1:0] c, input bit jm);
    return {(jm ? ~c[0] : c[0]), c[W-1:1]};
  endfunction

  function automatic logic [W-1:0] word_at(input int k, input bit jm);
    logic [W-1:0] w;
    w = W'(1);
    for (int i = 0; i < k; i++) w = nxt(w, jm);
    return w;
  endfunction

  // A word is legal iff it appears in the counter's cycle; its index is its position.
  task automatic lookup(input logic [W-1:0] c, input bit jm, output bit lg, output int k);
    logic [W-1:0] w;
    int per;
    per = jm ? 2*W : W;
    w   = W'(1);
    lg  = 1'b0;
    k   = 0;
    for (int i = 0; i < per; i++) begin
      if (!lg && w == c) begin
        lg = 1'b1;
        k  = i;
      end
      w = nxt(w, jm);
    end
  endtask

  // Reference model state, in sequence positions rather than code words.
  bit            mdl_ok = 1'b0;
  int            m_state, m_ref, m_run, m_miss;
  bit            m_mode;
  logic [IW-1:0] e_index;
  bit            e_iv, e_err, e_locked;
  int            e_cnt;

  task automatic model_step();
    bit lg;
    int k, per;
    e_iv  = 1'b0;
    e_err = 1'b0;
    if (!rstn) begin
      mdl_ok  = 1'b1;
      m_state = M_HUNT;
      m_run   = 0;
      m_miss  = 0;
      m_ref   = 0;
      m_mode  = j_r;
      e_index = '0;
      e_cnt   = 0;
    end else if (code_valid) begin
      if (j_r != m_mode) begin
        m_mode  = j_r;
        m_state = M_HUNT;
        m_run   = 0;
        m_miss  = 0;
      end else begin
        per = m_mode ? 2*W : W;
        lookup(code_in, m_mode, lg, k);
        if (lg) begin
          e_iv    = 1'b1;
          e_index = IW'(k);
        end
        if (m_state == M_HUNT) begin
          if (lg) begin
            m_ref = k;
            m_run = 1;
            if (m_run >= LC) begin
              m_state = M_LOCK;
              m_miss  = 0;
            end else begin
              m_state = M_ACQ;
            end
          end else begin
            e_err = 1'b1;
          end
        end else if (m_state == M_ACQ) begin
          if (!lg) begin
            e_err   = 1'b1;
            m_state = M_HUNT;
          end else if (k == (m_ref + 1) % per) begin
            m_ref = k;
            m_run++;
            if (m_run >= LC) begin
              m_state = M_LOCK;
              m_miss  = 0;
            end
          end else begin
            m_ref = k;
            m_run = 1;
          end
        end else begin
          if (lg && k == (m_ref + 1) % per) begin
            m_ref  = k;
            m_miss = 0;
          end else begin
            e_err  = 1'b1;
            m_miss++;
            m_ref  = (m_ref + 1) % per;
            if (m_miss >= ML) m_state = M_HUNT;
          end
        end
      end
`ifdef JR_DECODER_ERRCNT_EN
      if (e_err && e_cnt < 255) e_cnt++;
`endif
    end
    e_locked = (m_state == M_LOCK);
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    if (mdl_ok) begin
      chk("index", 32'(index), 32'(e_index));
      chk("index_valid", 32'(index_valid), 32'(e_iv));
      chk("locked", 32'(locked), 32'(e_locked));
      chk("err", 32'(err), 32'(e_err));
      chk("err_count", 32'(err_count), 32'(e_cnt));
    end
  end

  task automatic step(input bit v, input logic [W-1:0] c, input bit jm, input bit rs);
    rstn       = rs;
    code_valid = v;
    code_in    = c;
    j_r        = jm;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_index"}, 32'(index), 32'd0);
    chk({tag, "_iv"}, 32'(index_valid), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_cnt"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    int expcnt;
    bit gm;
    int sp, r, per;
    logic [W-1:0] c;

    rstn = 1'b0; code_valid = 1'b0; code_in = '0; j_r = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst");

    // Johnson acquisition
    step(1, 4'b0001, 1, 1); chk("j0_idx", 32'(index), 0); chk("j0_lock", 32'(locked), 0);
    step(1, 4'b0000, 1, 1); chk("j1_idx", 32'(index), 1); chk("j1_lock", 32'(locked), 1);
    step(1, 4'b1000, 1, 1); chk("j2_idx", 32'(index), 2);
    step(1, 4'b1100, 1, 1); chk("j3_idx", 32'(index), 3); chk("j3_err", 32'(err), 0);

    // Illegal injection while locked, then flywheel-predicted word accepted
    step(1, 4'b0101, 1, 1);
    chk("inj_err", 32'(err), 1); chk("inj_iv", 32'(index_valid), 0); chk("inj_lock", 32'(locked), 1);
`ifdef JR_DECODER_ERRCNT_EN
    expcnt = 1;
`else
    expcnt = 0;
`endif
    chk("inj_cnt", 32'(err_count), 32'(expcnt));
    step(1, 4'b1111, 1, 1); chk("fly_idx", 32'(index), 5); chk("fly_err", 32'(err), 0);

    // Two consecutive misses drop lock
    step(1, 4'b0101, 1, 1); chk("miss1_lock", 32'(locked), 1);
    step(1, 4'b0101, 1, 1); chk("miss2_lock", 32'(locked), 0); chk("miss2_err", 32'(err), 1);

    // Switch to ring: first sample dropped
    step(1, 4'b0001, 0, 1); chk("mode_iv", 32'(index_valid), 0); chk("mode_err", 32'(err), 0);
    step(1, 4'b0001, 0, 1); chk("r0_idx", 32'(index), 0); chk("r0_lock", 32'(locked), 0);
    step(1, 4'b1000, 0, 1); chk("r1_idx", 32'(index), 1); chk("r1_lock", 32'(locked), 1);
    step(1, 4'b0100, 0, 1); chk("r2_idx", 32'(index), 2);
    step(1, 4'b0010, 0, 1); chk("r3_idx", 32'(index), 3);
    step(1, 4'b0001, 0, 1); chk("r4_idx", 32'(index), 0); chk("r4_lock", 32'(locked), 1);

    // Toggle back to Johnson while locked
    step(1, 4'b0001, 1, 1); chk("tog_lock", 32'(locked), 0); chk("tog_iv", 32'(index_valid), 0);
    step(1, 4'b0001, 1, 1); chk("reacq0", 32'(locked), 0);
    step(1, 4'b0000, 1, 1); chk("reacq1", 32'(locked), 1);

    // Invalid cycle has no effect
    step(0, 4'b0101, 1, 1); chk("idle_iv", 32'(index_valid), 0); chk("idle_err", 32'(err), 0);
    chk("idle_lock", 32'(locked), 1);

    // Error counter saturation
    for (int i = 0; i < 300; i++) step(1, 4'b0101, 1, 1);
`ifdef JR_DECODER_ERRCNT_EN
    expcnt = 255;
`else
    expcnt = 0;
`endif
    chk("sat_cnt", 32'(err_count), 32'(expcnt));

    // Reset mid-acquisition, then normal acceptance
    step(1, 4'b0001, 1, 1);
    step(1, 4'b0000, 1, 0); chk_reset_vals("midrst");
    step(1, 4'b0000, 1, 1); chk("post_idx", 32'(index), 1); chk("post_iv", 32'(index_valid), 1);

    // Randomized stream: mostly in-sequence, with jumps, junk, repeats, mode flips, resets
    gm = 1'b1;
    sp = 1;
    for (int n = 0; n < 4000; n++) begin
      per = gm ? 2*W : W;
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 59) == 0) begin
          gm  = ~gm;
          per = gm ? 2*W : W;
          sp  = sp % per;
        end
        r = $urandom_range(0, 9);
        if (r < 7) begin
          sp = (sp + 1) % per;
          c  = word_at(sp, gm);
        end else if (r == 7) begin
          c = W'($urandom);
        end else if (r == 8) begin
          sp = $urandom_range(0, per - 1);
          c  = word_at(sp, gm);
        end else begin
          c = word_at(sp, gm);
        end
        step(1, c, gm, ($urandom_range(0, 199) != 0));
      end else begin
        step(0, W'($urandom), gm, ($urandom_range(0, 199) != 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jr_decoder.md
# jr_decoder

Receive-side companion to the ring/Johnson counter. Samples a WIDTH-bit ring or Johnson code word and decodes it to a binary sequence index. Checks that successive samples follow the counter's shift sequence, acquires and holds lock, and flags illegal or out-of-sequence codes. Sits downstream of a `jr_counter` output, or of any bus carrying its code, as a decoder and integrity monitor.

## Interface
- `WIDTH`, 4, code width; must be ≥ 2.
- `LOCK_COUNT`, 2, consecutive in-sequence legal samples required to declare lock; must be ≥ 1.
- `MISS_LIMIT`, 2, consecutive mismatches while locked that drop lock; must be ≥ 1.
- Derived: `IW = $clog2(2*WIDTH)`.
- `clk` input 1: single clock; all logic on rising edge.
- `rstn` input 1: reset; synchronous, active-low.
- `j_r` input 1: code mode; 1 = Johnson (period 2·WIDTH), 0 = ring (period WIDTH).
- `code_in` input WIDTH: sampled code word.
- `code_valid` input 1: qualifies `code_in` this cycle.
- `index` output IW: decoded index of the last legal sample.
- `index_valid` output 1: one-cycle pulse; `index` is updated.
- `locked` output 1: level; sequence lock held.
- `err` output 1: one-cycle pulse; illegal code, or mismatch while locked.
- `err_count` output 8: saturating error count.

## Operation
- Sequence convention (next-word function): `next(c) = {f, c[WIDTH-1:1]}`, where f = ~c[0] in Johnson mode and f = c[0] in ring mode. Index 0 = `1`.
- Ring legality and index:
  - Legal iff exactly one bit set.
  - Set bit at position p gives index = (WIDTH − p) mod WIDTH.
- Johnson legality and index:
  - Legal iff all-zero, or n ones packed at the MSB end (n = 1..WIDTH), or m ones packed at the LSB end (m = 1..WIDTH−1).
  - All-zero → index 1.
  - n ones at MSB end → index 1+n.
  - m ones at LSB end → index (2·WIDTH + 1 − m) mod 2·WIDTH.
- Internal state: `ref`, the last accepted or predicted word; `run` counter; `miss` counter; `mode_q`, the registered `j_r`.
- FSM state HUNT (acquiring a first legal word):
  - Legal sample: ref ← sample, run ← 1. Go to LOCKED if LOCK_COUNT = 1, else to ACQ.
  - Illegal sample: err, stay in HUNT.
- FSM state ACQ (counting in-sequence samples toward lock):
  - Sample = next(ref): ref ← sample, run++. Go to LOCKED when run reaches LOCK_COUNT.
  - Other legal sample: ref ← sample, run ← 1, stay in ACQ, no err.
  - Illegal sample: err, go to HUNT.
- FSM state LOCKED (tracking the sequence):
  - Sample = next(ref): ref ← sample, miss ← 0.
  - Any other sample, legal or not: err, miss++, and ref ← next(ref) (flywheel).
  - When miss reaches MISS_LIMIT: go to HUNT, `locked` deasserts.
- Cycles with `code_valid` = 0 have no effect on any state.
- `index`/`index_valid` update for every legal valid sample, in any state, including mismatching legal samples.
- Mode change: if `j_r` ≠ `mode_q`:
  - mode_q ← j_r; FSM goes to HUNT; run and miss clear.
  - That cycle's sample is dropped: no index_valid, no err.
- `err_count` increments on each err and saturates at 255.

## Timing
- All outputs registered. Response to a sample at edge k appears after edge k+1 (latency 1).
- `locked` rises in the same cycle as the `index_valid` of the locking sample. It falls in the same cycle as the `err` of the MISS_LIMIT-th miss.
- Reset (rstn = 0 at an edge) takes priority over everything, including mid-acquisition. Reset values:
  - FSM state HUNT; index 0; index_valid 0; locked 0; err 0; err_count 0; run 0; miss 0.
  - mode_q ← j_r.
- The cycle after reset releases accepts a sample normally.

## Configuration
- `JR_DECODER_ERRCNT_EN` defined: `err_count` is implemented as described.
- Not defined: the counter logic is omitted and `err_count` is tied to 0. `err` pulses are unchanged.

## Test plan
- Johnson, WIDTH=4, LOCK_COUNT=2: valid samples 0001, 0000, 1000, 1100 on consecutive cycles → index 0, 1, 2, 3. `locked` rises with index 1. No err.
- Ring: samples 0001, 1000, 0100, 0010, 0001 → index 0, 1, 2, 3, 0. Locked from the second sample.
- Locked Johnson stream, then inject 0101 → err pulse, no index_valid, err_count = 1, still locked. Next sample equals next(next(previous)) → accepted, miss clears.
- Locked, then two consecutive mismatches with MISS_LIMIT=2 → two err pulses. `locked` falls with the second pulse; FSM in HUNT.
- Toggle `j_r` while locked → that sample dropped, `locked` = 0 next cycle. Re-acquire in the new mode after LOCK_COUNT samples.
- Force 300 illegal samples → err_count saturates at 255. With `JR_DECODER_ERRCNT_EN` undefined, err_count stays 0. Assert rstn = 0 mid-ACQ → all outputs at reset values next cycle.
